// File: rtl/alu4_sched.sv
// Two-requester round-robin scheduler in front of a 4-bit ALU.
// One operation in flight: IDLE (grant/capture) -> EXEC (compute) -> DONE (hold until ack).
module alu4_sched (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       ack,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Returns {c, n, z, v, result[3:0]}; ADD/SUB share one adder, SUB as a + ~b + 1.
  function automatic logic [7:0] alu_calc(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [3:0] res_s;
    logic [3:0] bx_s;
    logic       cin_s;
    logic [4:0] sum_s;
    logic [3:0] low_s;
    logic       c_s;
    logic       v_s;
    res_s = 4'b0000;
    bx_s  = b;
    cin_s = 1'b0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op)
      3'b000:  res_s = ~a;
      3'b001:  res_s = ~b;
      3'b010:  res_s = a & b;
      3'b011:  res_s = a | b;
      3'b100:  res_s = a ^ b;
      3'b101:  res_s = ~(a ^ b);
      3'b110: begin
        bx_s  = b;
        cin_s = 1'b0;
      end
      3'b111: begin
        bx_s  = ~b;
        cin_s = 1'b1;
      end
      default: res_s = 4'b0000;
    endcase
    sum_s = {1'b0, a} + {1'b0, bx_s} + {4'b0000, cin_s};
    low_s = {1'b0, a[2:0]} + {1'b0, bx_s[2:0]} + {3'b000, cin_s};
    if (op[2:1] == 2'b11) begin
      res_s = sum_s[3:0];
      c_s   = sum_s[4];
      v_s   = sum_s[4] ^ low_s[3];
    end else begin
      c_s = 1'b0;
      v_s = 1'b0;
    end
    return {c_s, res_s[3], (res_s == 4'b0000), v_s, res_s};
  endfunction

  state_t     state_r, state_next_s;
  logic       last_id_r;
  logic [2:0] cap_op_r;
  logic [3:0] cap_a_r, cap_b_r;
  logic       cap_id_r;
  logic       grant_s, grant_id_s;
  logic [7:0] alu_s;
  logic       busy_r, done_r, done_id_r;
  logic [3:0] result_r;
  logic       c_r, n_r, z_r, v_r;

  assign alu_s = alu_calc(cap_op_r, cap_a_r, cap_b_r);

  // Arbitration, grant decode and next-state selection
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    grant_id_s   = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          grant_s    = 1'b1;
          grant_id_s = ~last_id_r;
        end else if (req0) begin
          grant_s    = 1'b1;
          grant_id_s = 1'b0;
        end else if (req1) begin
          grant_s    = 1'b1;
          grant_id_s = 1'b1;
        end else begin
          grant_s    = 1'b0;
          grant_id_s = 1'b0;
        end
        if (grant_s) begin
          state_next_s = ST_EXEC;
          gnt0         = ~grant_id_s;
          gnt1         = grant_id_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_DONE: begin
        if (ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, status outputs and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      last_id_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
      if ((state_r == ST_DONE) && ack) begin
        last_id_r <= done_id_r;
      end
    end
  end

  // Operand capture on the grant edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_op_r <= 3'b000;
      cap_a_r  <= 4'b0000;
      cap_b_r  <= 4'b0000;
      cap_id_r <= 1'b0;
    end else if (grant_s) begin
      cap_op_r <= grant_id_s ? op1 : op0;
      cap_a_r  <= grant_id_s ? a1 : a0;
      cap_b_r  <= grant_id_s ? b1 : b0;
      cap_id_r <= grant_id_s;
    end
  end

  // Result and flag registers, loaded only on the EXEC cycle and held through DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_r  <= 4'b0000;
      c_r       <= 1'b0;
      n_r       <= 1'b0;
      z_r       <= 1'b0;
      v_r       <= 1'b0;
      done_id_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r  <= alu_s[3:0];
      v_r       <= alu_s[4];
      z_r       <= alu_s[5];
      n_r       <= alu_s[6];
      c_r       <= alu_s[7];
      done_id_r <= cap_id_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign result  = result_r;
  assign c       = c_r;
  assign n       = n_r;
  assign z       = z_r;
  assign v       = v_r;

endmodule

// File: tb/tb_alu4_sched.sv
// Self-checking bench for alu4_sched: directed spec cases plus random traffic
// checked against an arithmetic reference model and a round-robin pointer model.
module tb_alu4_sched;
  logic       clk, reset_n, req0, req1, ack;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, done_id, c, n, z, v;
  logic [3:0] result;

  int   checks = 0;
  int   fails = 0;
  logic last_m = 1'b1;

  alu4_sched dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack(ack),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .c(c), .n(n), .z(z), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: {c, n, z, v, result} from unsigned/signed integer arithmetic
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, sr;
    logic cc, vv;
    logic [3:0] rb;
    ua = a; ub = b;
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    cc = 1'b0; vv = 1'b0; r = 0;
    case (op)
      3'd0: r = 15 - ua;
      3'd1: r = 15 - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 15 - (ua ^ ub);
      3'd6: begin
        r = (ua + ub) % 16; cc = (ua + ub) > 15;
        sr = sa + sb; vv = (sr > 7) || (sr < -8);
      end
      default: begin
        r = (ua - ub + 16) % 16; cc = (ua >= ub);
        sr = sa - sb; vv = (sr > 7) || (sr < -8);
      end
    endcase
    rb = r[3:0];
    return {cc, (r >= 8), (r == 0), vv, rb};
  endfunction

  // One complete transaction; caller must be away from a rising edge.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [2:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                         input logic [2:0] o1, input logic [3:0] x1, input logic [3:0] y1,
                         input logic keep, input logic ack_exec, input int hold,
                         output logic win);
    logic [7:0] exp_v;
    req0 = r0; req1 = r1;
    op0 = o0; a0 = x0; b0 = y0;
    op1 = o1; a1 = x1; b1 = y1;
    win = (r0 && r1) ? ~last_m : (r0 ? 1'b0 : 1'b1);
    exp_v = win ? model(o1, x1, y1) : model(o0, x0, y0);
    #1;
    checks++;
    if ({gnt0, gnt1} !== {~win, win}) begin
      fails++;
      $display("FAIL grant: got gnt0/gnt1=%b%b expected %b%b", gnt0, gnt1, ~win, win);
    end
    @(posedge clk); #1;
    if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
    if (ack_exec) ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, gnt0, gnt1} !== 4'b1000) begin
      fails++;
      $display("FAIL exec_state: got busy,done,gnt0,gnt1=%b expected 1000", {busy, done, gnt0, gnt1});
    end
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, done_id} !== {1'b1, 1'b1, win} || {c, n, z, v, result} !== exp_v) begin
      fails++;
      $display("FAIL done_result: got done=%b id=%b cnzv=%b%b%b%b res=%b expected id=%b cnzv/res=%b",
               done, done_id, c, n, z, v, result, win, exp_v);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({done, done_id} !== {1'b1, win} || {c, n, z, v, result} !== exp_v) begin
        fails++;
        $display("FAIL done_hold: cycle %0d got done=%b res=%b expected res=%b", i, done, result, exp_v[3:0]);
      end
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    last_m = win;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL after_ack: got busy,done=%b%b expected 00", busy, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
    op0 = 3'd0; op1 = 3'd0; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, busy, done, done_id, result, c, n, z, v} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {gnt0, gnt1, busy, done, done_id, result, c, n, z, v});
    end
    reset_n = 1'b1;
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, busy, done} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_no_req: got %b expected 0000", {gnt0, gnt1, busy, done});
    end
  endtask

  task automatic test_round_robin();
    logic w;
    logic [3:0] seq;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 3'b110, 4'd3, 4'd4, 3'b100, 4'd9, 4'd5, 1'b1, 1'b0, 0, w);
      seq[i] = w;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (seq !== 4'b1010) begin
      fails++;
      $display("FAIL round_robin: got winners (lsb first)=%b expected 1010", seq);
    end
  endtask

  task automatic test_directed();
    logic w;
    run_txn(1'b1, 1'b0, 3'b110, 4'b0111, 4'b0001, 3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 0, w);
    checks++;
    if ({result, n, v, c, z} !== 8'b1000_1100) begin
      fails++;
      $display("FAIL add_overflow: got res=%b nvcz=%b%b%b%b expected 1000 1100", result, n, v, c, z);
    end
    run_txn(1'b0, 1'b1, 3'b000, 4'd0, 4'd0, 3'b111, 4'b0011, 4'b0011, 1'b0, 1'b0, 0, w);
    checks++;
    if ({result, z, c, v, n} !== 8'b0000_1100) begin
      fails++;
      $display("FAIL sub_equal: got res=%b zcvn=%b%b%b%b expected 0000 1100", result, z, c, v, n);
    end
    run_txn(1'b1, 1'b0, 3'b110, 4'b1111, 4'b0001, 3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 0, w);
    checks++;
    if ({result, c, z, v} !== 7'b0000_110) begin
      fails++;
      $display("FAIL add_wrap: got res=%b czv=%b%b%b expected 0000 110", result, c, z, v);
    end
  endtask

  task automatic test_hold();
    logic w;
    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL ack_in_idle: got busy,done=%b%b expected 00", busy, done);
    end
    run_txn(1'b1, 1'b0, 3'b010, 4'b1100, 4'b1010, 3'b000, 4'd0, 4'd0, 1'b0, 1'b1, 5, w);
    checks++;
    if ({result, c, v} !== 6'b1000_00) begin
      fails++;
      $display("FAIL and_op: got res=%b cv=%b%b expected 1000 00", result, c, v);
    end
  endtask

  task automatic test_random();
    logic w;
    int mode;
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(2, 0);
      run_txn(mode != 1, mode != 0,
              3'($urandom), 4'($urandom), 4'($urandom),
              3'($urandom), 4'($urandom), 4'($urandom),
              1'b0, 1'($urandom), $urandom_range(2, 0), w);
    end
  endtask

  task automatic test_reset_exec();
    logic w;
    run_txn(1'b0, 1'b1, 3'b000, 4'd0, 4'd0, 3'b011, 4'b1010, 4'b0101, 1'b0, 1'b0, 0, w);
    req0 = 1'b1; op0 = 3'b110; a0 = 4'd5; b0 = 4'd6;
    @(posedge clk); #1;
    req0 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, done, done_id, result, c, n, z, v} !== 13'd0) begin
      fails++;
      $display("FAIL reset_in_exec: got %b expected all zero",
               {gnt0, gnt1, busy, done, done_id, result, c, n, z, v});
    end
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        fails++;
        $display("FAIL no_result_after_reset: got busy,done=%b%b expected 00", busy, done);
      end
    end
    run_txn(1'b1, 1'b1, 3'b011, 4'd1, 4'd2, 3'b100, 4'd7, 4'd7, 1'b0, 1'b0, 0, w);
    checks++;
    if (done_id !== 1'b0 || w !== 1'b0) begin
      fails++;
      $display("FAIL tie_after_reset: got done_id=%b expected 0", done_id);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_hold();
    test_random();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
